// File: rtl/cu_hmi_pkg.sv
// cu_hmi_pkg: shared definitions for the host-link command decoder.
//   - opcode constants (din[7:6])
//   - control sub-codes (din[5:4] of the control opcode)
//   - decoder FSM state encoding
//   - small helper for one-hot checking of the read group field
package cu_hmi_pkg;

   localparam logic [1:0] OP_CTRL = 2'b00;
   localparam logic [1:0] OP_READ = 2'b01;
   localparam logic [1:0] OP_ADDR = 2'b10;
   localparam logic [1:0] OP_SEL  = 2'b11;

   localparam logic [1:0] CTRL_RST  = 2'b00;
   localparam logic [1:0] CTRL_RDAC = 2'b01;
   localparam logic [1:0] CTRL_INC  = 2'b10;
   localparam logic [1:0] CTRL_PAGE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CAPTURE  = 3'd1,
      ST_DECODE   = 3'd2,
      ST_PULSE    = 3'd3,
      ST_WAIT_LOW = 3'd4
   } state_t;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/cu_hmi_mc_sync_edge.sv
// sync_edge: two-flop synchroniser plus rising-edge detector for a
// single asynchronous level coming from the UART side.
//   clk   in  system clock
//   res   in  asynchronous active-low reset
//   d     in  asynchronous level
//   level out synchronised level (second flop)
//   rise  out one-cycle pulse on a synchronised 0->1 transition
module sync_edge (
   input  logic clk,
   input  logic res,
   input  logic d,
   output logic level,
   output logic rise
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchroniser chain plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   // Built only from flops, so the edge pulse is glitch-free.
   assign level = sync_r;
   assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/cu_hmi_mc.sv
// cu_hmi_mc: host-link command decoder driving the TDC board controls.
// Ports:
//   clk, res           clock, asynchronous active-low reset
//   din, din_rdy       received byte and its (asynchronous) valid level
//   in_value           board ID from DIP switches
//   address            paged channel address
//   reset, res_dac     global reset / all-DAC reset strobes
//   inc_dac            per-DAC increment strobes
//   read, read_sel     read strobe and one-hot read group
//   fpga_sel           board selected
//   fpga_sel_status    last select byte
//   cmd_err            one-cycle flag for invalid/unaddressed command
//   busy               command in progress until din_rdy returns low
module cu_hmi_mc
   import cu_hmi_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int N_DAC     = 2,
   parameter int ID_W      = 3,
   parameter int PULSE_LEN = 4
) (
   input  logic              clk,
   input  logic              res,
   input  logic [7:0]        din,
   input  logic              din_rdy,
   input  logic [ID_W-1:0]   in_value,
   output logic [ADDR_W-1:0] address,
   output logic              reset,
   output logic              res_dac,
   output logic [N_DAC-1:0]  inc_dac,
   output logic              read,
   output logic [2:0]        read_sel,
   output logic              fpga_sel,
   output logic [7:0]        fpga_sel_status,
   output logic              cmd_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(PULSE_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(6'h3F);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
   localparam logic [N_DAC-1:0]  DAC_ONE  = N_DAC'(1'b1);

   state_t state_r, state_nxt;

   logic              rdy_sync_s;
   logic              rdy_rise_s;
   logic [7:0]        cmd_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              auto_r;
   logic [ADDR_W-1:0] address_r;
   logic              reset_r, res_dac_r, read_r, fpga_sel_r, cmd_err_r, busy_r;
   logic [N_DAC-1:0]  inc_dac_r;
   logic [2:0]        read_sel_r;
   logic [7:0]        status_r;

   // decode results, only consumed in DECODE
   logic              err_s, str_rst_s, str_rdac_s, str_read_s, auto_s, strobe_any_s;
   logic [N_DAC-1:0]  str_inc_s;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic              sel_nxt_s;
   logic [7:0]        status_nxt_s;
   logic [2:0]        rsel_nxt_s;

   sync_edge u_rdy_sync (
      .clk   (clk),
      .res   (res),
      .d     (din_rdy),
      .level (rdy_sync_s),
      .rise  (rdy_rise_s)
   );

   // Command decode of the latched byte.
   always_comb begin
      err_s        = 1'b0;
      str_rst_s    = 1'b0;
      str_rdac_s   = 1'b0;
      str_read_s   = 1'b0;
      auto_s       = 1'b0;
      str_inc_s    = {N_DAC{1'b0}};
      addr_nxt_s   = address_r;
      sel_nxt_s    = fpga_sel_r;
      status_nxt_s = status_r;
      rsel_nxt_s   = read_sel_r;
      case (cmd_r[7:6])
         OP_SEL: begin
            sel_nxt_s    = (cmd_r[ID_W-1:0] == in_value);
            status_nxt_s = cmd_r;
         end
         OP_CTRL: begin
            // the global reset works on every board, selected or not
            if (cmd_r == 8'h00) begin
               str_rst_s = 1'b1;
            end else if (!fpga_sel_r) begin
               err_s = 1'b1;
            end else begin
               case (cmd_r[5:4])
                  CTRL_RDAC: str_rdac_s = 1'b1;
                  CTRL_INC: begin
                     if ({1'b0, cmd_r[3:0]} >= 5'(N_DAC)) begin
                        err_s = 1'b1;
                     end else begin
                        str_inc_s = DAC_ONE << cmd_r[3:0];
                     end
                  end
                  CTRL_PAGE: begin
                     // page bits land at [ADDR_W-1:6]; no page bits exist at 6
                     if (ADDR_W == 6) begin
                        err_s = 1'b1;
                     end else begin
                        addr_nxt_s = (address_r & LOW_MASK) |
                                     ADDR_W'({cmd_r[3:0], 6'b000000});
                     end
                  end
                  CTRL_RST: err_s = 1'b1;   // 00_00_xxxx other than 0x00
                  default:  err_s = 1'b1;
               endcase
            end
         end
         OP_READ: begin
            if (!fpga_sel_r) begin
               err_s = 1'b1;
            end else if (!is_onehot3(cmd_r[2:0])) begin
               err_s = 1'b1;
            end else begin
               str_read_s = 1'b1;
               rsel_nxt_s = cmd_r[2:0];
               auto_s     = cmd_r[5];
            end
         end
         OP_ADDR: begin
            if (!fpga_sel_r) begin
               err_s = 1'b1;
            end else begin
               addr_nxt_s = (address_r & ~LOW_MASK) | ADDR_W'(cmd_r[5:0]);
            end
         end
         default: err_s = 1'b1;
      endcase
      strobe_any_s = str_rst_s | str_rdac_s | (|str_inc_s) | str_read_s;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // FSM next-state logic; only a rising edge seen in IDLE starts a command.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rdy_rise_s) state_nxt = ST_CAPTURE;
            else            state_nxt = ST_IDLE;
         end
         ST_CAPTURE: state_nxt = ST_DECODE;
         ST_DECODE: begin
            if (strobe_any_s) state_nxt = ST_PULSE;
            else              state_nxt = ST_WAIT_LOW;
         end
         ST_PULSE: begin
            if (cnt_r == CNT_ZERO) state_nxt = ST_WAIT_LOW;
            else                   state_nxt = ST_PULSE;
         end
         ST_WAIT_LOW: begin
            if (!rdy_sync_s) state_nxt = ST_IDLE;
            else             state_nxt = ST_WAIT_LOW;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: byte latch, register updates, strobe timing, auto-increment.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         cmd_r      <= 8'h00;
         cnt_r      <= CNT_ZERO;
         auto_r     <= 1'b0;
         address_r  <= {ADDR_W{1'b0}};
         reset_r    <= 1'b0;
         res_dac_r  <= 1'b0;
         inc_dac_r  <= {N_DAC{1'b0}};
         read_r     <= 1'b0;
         read_sel_r <= 3'b000;
         fpga_sel_r <= 1'b0;
         status_r   <= 8'h00;
         cmd_err_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         cmd_err_r <= 1'b0;
         busy_r    <= (state_nxt != ST_IDLE);
         case (state_r)
            ST_CAPTURE: cmd_r <= din;
            ST_DECODE: begin
               address_r  <= addr_nxt_s;
               fpga_sel_r <= sel_nxt_s;
               status_r   <= status_nxt_s;
               read_sel_r <= rsel_nxt_s;
               cmd_err_r  <= err_s;
               reset_r    <= str_rst_s;
               res_dac_r  <= str_rdac_s;
               inc_dac_r  <= str_inc_s;
               read_r     <= str_read_s;
               auto_r     <= auto_s;
               cnt_r      <= CNT_LOAD;
            end
            ST_PULSE: begin
               if (cnt_r == CNT_ZERO) begin
                  reset_r   <= 1'b0;
                  res_dac_r <= 1'b0;
                  inc_dac_r <= {N_DAC{1'b0}};
                  read_r    <= 1'b0;
                  auto_r    <= 1'b0;
                  // wraps through the page bits as well
                  if (auto_r) begin
                     address_r <= address_r + ADDR_ONE;
                  end else begin
                     address_r <= address_r;
                  end
               end else begin
                  cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            default: cmd_r <= cmd_r;
         endcase
      end
   end

   assign address         = address_r;
   assign reset           = reset_r;
   assign res_dac         = res_dac_r;
   assign inc_dac         = inc_dac_r;
   assign read            = read_r;
   assign read_sel        = read_sel_r;
   assign fpga_sel        = fpga_sel_r;
   assign fpga_sel_status = status_r;
   assign cmd_err         = cmd_err_r;
   assign busy            = busy_r;

endmodule

// File: tb/tb_cu_hmi_mc.sv
// Scoreboard bench for cu_hmi_mc (ADDR_W=8, N_DAC=2, ID_W=3, PULSE_LEN=4).
module tb_cu_hmi_mc;

   localparam int PL = 4;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_rdy = 1'b0;
   logic [2:0] in_value = 3'b111;
   logic [7:0] address;
   logic       reset, res_dac, read, fpga_sel, cmd_err, busy;
   logic [1:0] inc_dac;
   logic [2:0] read_sel;
   logic [7:0] fpga_sel_status;

   cu_hmi_mc #(.ADDR_W(8), .N_DAC(2), .ID_W(3), .PULSE_LEN(PL)) dut (
      .clk(clk), .res(res), .din(din), .din_rdy(din_rdy), .in_value(in_value),
      .address(address), .reset(reset), .res_dac(res_dac), .inc_dac(inc_dac),
      .read(read), .read_sel(read_sel), .fpga_sel(fpga_sel),
      .fpga_sel_status(fpga_sel_status), .cmd_err(cmd_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // kind: 0 none, 1 reset, 2 res_dac, 3 inc_dac, 4 read
   typedef struct {
      logic [7:0] b;
      logic       err;
      int         kind;
      logic [2:0] rsel;
      logic [1:0] inc;
      logic [7:0] addr;
      logic       sel;
      logic [7:0] st;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // monitor accumulators
   int err_cnt = 0, rst_cyc = 0, rdac_cyc = 0, inc_cyc = 0, read_cyc = 0;
   logic [1:0] inc_or = 2'b00;
   logic busy_q = 1'b0;

   // Monitor: accumulates strobe activity per command, compares on busy fall.
   initial forever begin
      @(negedge clk);
      if (!res) begin
         err_cnt = 0; rst_cyc = 0; rdac_cyc = 0; inc_cyc = 0; read_cyc = 0;
         inc_or = 2'b00; busy_q = 1'b0;
      end else begin
         err_cnt  += int'(cmd_err);
         rst_cyc  += int'(reset);
         rdac_cyc += int'(res_dac);
         inc_cyc  += int'(|inc_dac);
         read_cyc += int'(read);
         inc_or   |= inc_dac;
         if (busy_q && !busy) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("cmd_err[%02h]", e.b), err_cnt, {31'd0, e.err});
               chk($sformatf("reset_len[%02h]", e.b), rst_cyc, (e.kind == 1) ? PL : 0);
               chk($sformatf("res_dac_len[%02h]", e.b), rdac_cyc, (e.kind == 2) ? PL : 0);
               chk($sformatf("inc_len[%02h]", e.b), inc_cyc, (e.kind == 3) ? PL : 0);
               chk($sformatf("inc_mask[%02h]", e.b), {30'd0, inc_or}, {30'd0, e.inc});
               chk($sformatf("read_len[%02h]", e.b), read_cyc, (e.kind == 4) ? PL : 0);
               chk($sformatf("read_sel[%02h]", e.b), {29'd0, read_sel}, {29'd0, e.rsel});
               chk($sformatf("address[%02h]", e.b), {24'd0, address}, {24'd0, e.addr});
               chk($sformatf("fpga_sel[%02h]", e.b), {31'd0, fpga_sel}, {31'd0, e.sel});
               chk($sformatf("status[%02h]", e.b), {24'd0, fpga_sel_status}, {24'd0, e.st});
            end
            err_cnt = 0; rst_cyc = 0; rdac_cyc = 0; inc_cyc = 0; read_cyc = 0;
            inc_or = 2'b00;
         end
         busy_q = busy;
      end
   end

   task automatic send(input logic [7:0] b, input logic err, input int kind,
                       input logic [2:0] rsel, input logic [1:0] inc,
                       input logic [7:0] addr, input logic sel, input logic [7:0] st,
                       input bit repulse);
      exp_t e;
      int k;
      e.b = b; e.err = err; e.kind = kind; e.rsel = rsel; e.inc = inc;
      e.addr = addr; e.sel = sel; e.st = st;
      sb.push_back(e);
      @(negedge clk);
      din = b; din_rdy = 1'b1;
      repeat (4) @(negedge clk);
      din_rdy = 1'b0;
      if (repulse) begin
         k = 0;
         while (!read && k < 20) begin @(negedge clk); k++; end
         if (!read) chk("repulse_wait_read", 32'd0, 32'd1);
         din = 8'h8A; din_rdy = 1'b1;
         repeat (3) @(negedge clk);
         din_rdy = 1'b0;
      end
      k = 0;
      while (busy && k < 60) begin @(negedge clk); k++; end
      if (busy) chk($sformatf("busy_timeout[%02h]", b), 32'd1, 32'd0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("rst_address", {24'd0, address}, 32'd0);
      chk("rst_strobes", {27'd0, reset, res_dac, inc_dac, read}, 32'd0);
      chk("rst_sel", {20'd0, fpga_sel, fpga_sel_status, read_sel}, 32'd0);
      chk("rst_err_busy", {30'd0, cmd_err, busy}, 32'd0);
      res = 1'b1;
      repeat (3) @(negedge clk);

      //    byte   err   kind rsel    inc    addr   sel   status rep
      send(8'hC7, 1'b0, 0, 3'b000, 2'b00, 8'h00, 1'b1, 8'hC7, 1'b0);
      send(8'hC0, 1'b0, 0, 3'b000, 2'b00, 8'h00, 1'b0, 8'hC0, 1'b0);
      send(8'h85, 1'b1, 0, 3'b000, 2'b00, 8'h00, 1'b0, 8'hC0, 1'b0);
      send(8'hC7, 1'b0, 0, 3'b000, 2'b00, 8'h00, 1'b1, 8'hC7, 1'b0);
      send(8'h85, 1'b0, 0, 3'b000, 2'b00, 8'h05, 1'b1, 8'hC7, 1'b0);
      send(8'h44, 1'b0, 4, 3'b100, 2'b00, 8'h05, 1'b1, 8'hC7, 1'b0);
      send(8'h42, 1'b0, 4, 3'b010, 2'b00, 8'h05, 1'b1, 8'hC7, 1'b0);
      send(8'h41, 1'b0, 4, 3'b001, 2'b00, 8'h05, 1'b1, 8'hC7, 1'b0);
      send(8'h43, 1'b1, 0, 3'b001, 2'b00, 8'h05, 1'b1, 8'hC7, 1'b0);
      send(8'h33, 1'b0, 0, 3'b001, 2'b00, 8'hC5, 1'b1, 8'hC7, 1'b0);
      send(8'hBF, 1'b0, 0, 3'b001, 2'b00, 8'hFF, 1'b1, 8'hC7, 1'b0);
      send(8'h61, 1'b0, 4, 3'b001, 2'b00, 8'h00, 1'b1, 8'hC7, 1'b0);
      send(8'h61, 1'b0, 4, 3'b001, 2'b00, 8'h01, 1'b1, 8'hC7, 1'b0);
      send(8'h21, 1'b0, 3, 3'b001, 2'b10, 8'h01, 1'b1, 8'hC7, 1'b0);
      send(8'h22, 1'b1, 0, 3'b001, 2'b00, 8'h01, 1'b1, 8'hC7, 1'b0);
      send(8'h10, 1'b0, 2, 3'b001, 2'b00, 8'h01, 1'b1, 8'hC7, 1'b0);
      send(8'hC0, 1'b0, 0, 3'b001, 2'b00, 8'h01, 1'b0, 8'hC0, 1'b0);
      send(8'h00, 1'b0, 1, 3'b001, 2'b00, 8'h01, 1'b0, 8'hC0, 1'b0);
      send(8'h41, 1'b1, 0, 3'b001, 2'b00, 8'h01, 1'b0, 8'hC0, 1'b0);
      send(8'hC7, 1'b0, 0, 3'b001, 2'b00, 8'h01, 1'b1, 8'hC7, 1'b0);
      // second byte (0x8A) arrives during the strobe and must be dropped
      send(8'h41, 1'b0, 4, 3'b001, 2'b00, 8'h01, 1'b1, 8'hC7, 1'b1);
      send(8'h85, 1'b0, 0, 3'b001, 2'b00, 8'h05, 1'b1, 8'hC7, 1'b0);
      chk("sb_empty", sb.size(), 32'd0);

      // reset asserted in the middle of a read strobe
      @(negedge clk);
      din = 8'h44; din_rdy = 1'b1;
      k = 0;
      while (!read && k < 20) begin @(negedge clk); k++; end
      chk("mid_read_started", {31'd0, read}, 32'd1);
      #2 res = 1'b0;
      #1;
      chk("mid_rst_strobes", {27'd0, reset, res_dac, inc_dac, read}, 32'd0);
      chk("mid_rst_address", {24'd0, address}, 32'd0);
      chk("mid_rst_sel", {20'd0, fpga_sel, fpga_sel_status, read_sel}, 32'd0);
      chk("mid_rst_err_busy", {30'd0, cmd_err, busy}, 32'd0);
      din_rdy = 1'b0;
      repeat (3) @(negedge clk);
      res = 1'b1;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
